// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM with byte-lane writes, programmable
// wait states, a one-cycle ready pulse and an out-of-range error flag.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_a_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        busy_o
);

  localparam int WC    = (WAIT_CYCLES > 7) ? 7 : ((WAIT_CYCLES < 0) ? 0 : WAIT_CYCLES);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } req_t;

  state_t      state, nxt;
  logic [2:0]  cnt, cnt_nxt;
  req_t        cap, cur;
  logic        oor;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [3:0][7:0] ram [DEPTH];

  logic unused_a;
  assign unused_a = ^mem_a_i[1:0];

  // With zero wait states RESP is entered on the accept edge, so the range
  // check and read must see the live request rather than the capture.
  always_comb begin
    cur = cap;
    if (state == IDLE) begin
      cur.we    = mem_we_i;
      cur.addr  = mem_a_i[31:2];
      cur.sel   = mem_sel_i;
      cur.wdata = mem_data_i;
    end
  end

  assign oor = |cur.addr[29:ADDR_WIDTH];

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (mem_ce_i) begin
        cnt_nxt = 3'(WC);
        nxt     = (WC > 0) ? WAIT : RESP;
      end
      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1) nxt = RESP;
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      cap     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && mem_ce_i) cap <= cur;
      rdata_q <= (nxt == RESP && !cur.we && !oor) ? ram[cur.addr[ADDR_WIDTH-1:0]] : '0;
      err_q   <= (nxt == RESP) && oor;
    end
  end

  // Write commits on the edge leaving RESP; reset forces state to IDLE so an
  // interrupted write never reaches this edge.
  always_ff @(posedge clk_i) begin
    if (state == RESP && cap.we && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (cap.sel[i]) ram[cap.addr[ADDR_WIDTH-1:0]][i] <= cap.wdata[8*i +: 8];
      end
    end
  end

  assign mem_ready_o = (state == RESP);
  assign mem_err_o   = err_q & mem_ready_o;
  assign mem_data_o  = rdata_q;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: dut 0 has no wait states, dut 1 has three.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       ce, we;
  logic [1:0][31:0] a, wd;
  logic [1:0][3:0]  sel;
  logic [1:0][31:0] rd;
  logic [1:0]       rdy, err, busy;

  int nvec = 0;
  int nerr = 0;
  int lat [2] = '{0, 3};

  typedef struct {
    int          d;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_a_i(a[0]),
    .mem_sel_i(sel[0]), .mem_data_i(wd[0]), .mem_data_o(rd[0]), .mem_ready_o(rdy[0]),
    .mem_err_o(err[0]), .busy_o(busy[0]));

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_a_i(a[1]),
    .mem_sel_i(sel[1]), .mem_data_i(wd[1]), .mem_data_o(rd[1]), .mem_ready_o(rdy[1]),
    .mem_err_o(err[1]), .busy_o(busy[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: request is accepted at the next rising edge.
  task automatic xact(input int d, input logic w, input logic [31:0] addr,
                      input logic [3:0] s, input logic [31:0] data,
                      input logic [31:0] exp_d, input logic exp_e);
    int   k;
    exp_t e;
    sb.push_back('{d: d, data: exp_d, err: exp_e});
    ce[d] = 1'b1; we[d] = w; a[d] = addr; sel[d] = s; wd[d] = data;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      chk($sformatf("busy_d%0d_k%0d", d, k), 32'(busy[d]), 32'd1);
    end while (!rdy[d] && k < 12);
    chk($sformatf("latency_d%0d", d), k, lat[d] + 1);
    e = sb.pop_front();
    chk($sformatf("rdata_d%0d_a%h", e.d, addr), rd[e.d], e.data);
    chk($sformatf("err_d%0d_a%h", e.d, addr), 32'(err[e.d]), 32'(e.err));
    ce[d] = 1'b0;
    a[d]  = 32'hFFFF_FFFC;
    wd[d] = 32'h0BAD_0BAD;
    @(negedge clk);
    chk($sformatf("ready_width_d%0d", d), 32'(rdy[d]), 32'd0);
    chk($sformatf("idle_busy_d%0d", d), 32'(busy[d]), 32'd0);
    chk($sformatf("idle_data_d%0d", d), rd[d], 32'd0);
  endtask

  initial begin
    rst = 1'b1; ce = '0; we = '0; a = '0; wd = '0; sel = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_data_d%0d", d), rd[d], 32'd0);
      chk($sformatf("rst_flags_d%0d", d), {29'd0, rdy[d], err[d], busy[d]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // zero wait states: full-word write then read-back
    xact(0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'd0, 0);
    xact(0, 0, 32'h10, 4'h3, 32'h0, 32'hDEAD_BEEF, 0);

    // byte lanes and empty select
    xact(0, 1, 32'h20, 4'hF, 32'h1122_3344, 32'd0, 0);
    xact(0, 1, 32'h20, 4'b0100, 32'hAAAA_AAAA, 32'd0, 0);
    xact(0, 0, 32'h20, 4'hF, 32'h0, 32'h11AA_3344, 0);
    xact(0, 1, 32'h20, 4'h0, 32'h5555_5555, 32'd0, 0);
    xact(0, 0, 32'h23, 4'h0, 32'h0, 32'h11AA_3344, 0);

    // out of range must not alias onto word 0
    xact(0, 1, 32'h0, 4'hF, 32'h1234_5678, 32'd0, 0);
    xact(0, 1, 32'h0001_0000, 4'hF, 32'hCAFE_F00D, 32'd0, 1);
    xact(0, 0, 32'h0, 4'hF, 32'h0, 32'h1234_5678, 0);
    xact(0, 0, 32'h0001_0000, 4'hF, 32'h0, 32'd0, 1);
    xact(0, 0, 32'h8000_0004, 4'hF, 32'h0, 32'd0, 1);

    // three wait states, including the top word of the RAM
    xact(1, 1, 32'h30, 4'hF, 32'h0000_0005, 32'd0, 0);
    xact(1, 1, 32'h3FFC, 4'hF, 32'hA5A5_5A5A, 32'd0, 0);
    xact(1, 0, 32'h3FFC, 4'hF, 32'h0, 32'hA5A5_5A5A, 0);
    xact(1, 0, 32'h30, 4'hF, 32'h0, 32'h0000_0005, 0);

    // reset during WAIT of a write aborts it
    ce[1] = 1'b1; we[1] = 1'b1; a[1] = 32'h30; sel[1] = 4'hF; wd[1] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ce[1] = 1'b0;
    #1;
    chk("rst_mid_flags", {29'd0, rdy[1], err[1], busy[1]}, 32'd0);
    chk("rst_mid_data", rd[1], 32'd0);
    @(negedge clk);
    chk("rst_hold_flags", {29'd0, rdy[1], err[1], busy[1]}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("no_ready_after_rst_k%0d", k), 32'(rdy[1]), 32'd0);
    end
    xact(1, 0, 32'h30, 4'hF, 32'h0, 32'h0000_0005, 0);

    // held request: one response every 2+WAIT_CYCLES cycles
    ce[1] = 1'b1; we[1] = 1'b0; a[1] = 32'h30; sel[1] = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("hold_ready_k%0d", k), 32'(rdy[1]), 32'((k % 5) == 4));
      if (k % 5 == 4) chk($sformatf("hold_data_k%0d", k), rd[1], 32'h5);
    end
    ce[1] = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
